bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 149 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double-dabble, one bit per cycle).
//
// Takes an unsigned binary value and produces DIGITS packed BCD nibbles for the
// per-digit 7-segment decoders. Values above 10^DIGITS-1 saturate to all nines
// and raise overflow.
//
// Optional feature: define BIN2BCD_BLANK_EN to generate registered leading-zero
// blank flags. Without it, blank is tied to zero.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request conversion of bin (sampled only when idle)
//   bin       in   [WIDTH-1:0] unsigned value, captured on the accepting edge
//   busy      out  conversion in progress
//   done      out  one-cycle pulse, results valid/updated in this cycle
//   bcd       out  [4*DIGITS-1:0] packed BCD, digit 0 in bits [3:0]
//   overflow  out  last captured value exceeded 10^DIGITS-1
//   blank     out  [DIGITS-1:0] leading-zero blank flags
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [DIGITS-1:0]   blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

    localparam logic [31:0] MAXV = pow10(DIGITS) - 32'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [BW+WIDTH-1:0] sr, sr_nxt;    // {BCD field, binary field}
    logic [BW-1:0]      adj;
    logic [CW-1:0]      cnt;
    logic               ovf_pend;
    logic               load, last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5, then shift the whole register.
    // Bits leaving the top of the BCD field only occur on overflow, where the
    // result is replaced by all nines anyway.
    always_comb begin
        adj = sr[BW+WIDTH-1:WIDTH];
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH+4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
        end
        sr_nxt = {adj, sr[WIDTH-1:0]} << 1;
    end

    assign busy = (state == SHIFT);

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                sr       <= {{BW{1'b0}}, bin};
                cnt      <= CW'(WIDTH);
                ovf_pend <= (32'(bin) > MAXV);
            end else if (state == SHIFT) begin
                sr  <= sr_nxt;
                cnt <= cnt - CW'(1);
            end
            if (last) begin
                bcd      <= ovf_pend ? {DIGITS{4'h9}} : sr_nxt[BW+WIDTH-1:WIDTH];
                overflow <= ovf_pend;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Digit i blanks when it and every more-significant digit are zero.
    // Digit 0 never blanks so a zero value still shows a single "0".
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (sr_nxt[WIDTH+4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above & ~ovf_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       blank <= BLANK_RST;
        else if (last) blank <= blank_nxt;
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int W = 14;
    localparam int D = 4;
    localparam int MAXV = 9999;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [W-1:0]   bin;
    logic           busy, done, overflow;
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;

    int nchk = 0;
    int nerr = 0;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .blank(blank)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [4*D-1:0] exp_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned x;
        if (v > MAXV) return {D{4'h9}};
        x = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] exp_blank(input int unsigned v);
        logic [D-1:0] b;
        int unsigned p;
        b = '0;
`ifdef BIN2BCD_BLANK_EN
        p = 1;
        for (int i = 1; i < D; i++) begin
            p = p * 10;
            b[i] = (v < p) && (v <= MAXV);
        end
`endif
        return b;
    endfunction

    function automatic logic [D-1:0] exp_blank_rst();
`ifdef BIN2BCD_BLANK_EN
        return ~D'(1);
`else
        return '0;
`endif
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int unsigned v);
        start = 1'b1;
        bin   = W'(v);
        tick();
        start = 1'b0;
    endtask

    // Starting from cycle number cyc_in, advance until done is seen.
    // cyc_out = cycle in which done was high (-1 on timeout);
    // busy_ok = busy high and done low in every cycle before it.
    task automatic wait_done(input int cyc_in, output int cyc_out, output bit busy_ok);
        int c;
        c = cyc_in;
        busy_ok = 1'b1;
        while (!done && c < 100) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            c++;
        end
        cyc_out = done ? c : -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin = '0;
        tick(); tick();
        rst = 1'b0;
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0 || overflow !== 1'b0
            || blank !== exp_blank_rst()) begin
            nerr++;
            $display("FAIL reset: busy=%b done=%b bcd=%h ovf=%b blank=%b want 0 0 0000 0 %b",
                     busy, done, bcd, overflow, blank, exp_blank_rst());
        end
    endtask

    task automatic test_convert(input string name, input int unsigned v);
        int  cyc;
        bit  bok;
        kick(v);
        wait_done(1, cyc, bok);
        nchk++;
        if (cyc !== W + 1 || !bok || busy !== 1'b0) begin
            nerr++;
            $display("FAIL %s timing: done cycle=%0d busy_ok=%b busy_at_done=%b want %0d 1 0",
                     name, cyc, bok, busy, W + 1);
        end
        nchk++;
        if (bcd !== exp_bcd(v) || overflow !== (v > MAXV) || blank !== exp_blank(v)) begin
            nerr++;
            $display("FAIL %s value v=%0d: bcd=%h ovf=%b blank=%b want %h %b %b",
                     name, v, bcd, overflow, blank, exp_bcd(v), (v > MAXV), exp_blank(v));
        end
        // done must be a single-cycle pulse and results must hold while idle
        tick(); tick(); tick();
        nchk++;
        if (done !== 1'b0 || busy !== 1'b0 || bcd !== exp_bcd(v) || overflow !== (v > MAXV)) begin
            nerr++;
            $display("FAIL %s hold: done=%b busy=%b bcd=%h ovf=%b want 0 0 %h %b",
                     name, done, busy, bcd, overflow, exp_bcd(v), (v > MAXV));
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, extra;
        bit bok;
        kick(205);                       // now in cycle 1
        tick(); tick(); tick();          // cycle 4
        start = 1'b1; bin = W'(77);
        tick();                          // cycle 5
        start = 1'b0;
        wait_done(5, cyc, bok);
        nchk++;
        if (cyc !== W + 1 || bcd !== exp_bcd(205) || blank !== exp_blank(205)) begin
            nerr++;
            $display("FAIL ignore_busy: cycle=%0d bcd=%h blank=%b want %0d %h %b",
                     cyc, bcd, blank, W + 1, exp_bcd(205), exp_blank(205));
        end
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) extra++;
        end
        nchk++;
        if (extra !== 0 || bcd !== exp_bcd(205)) begin
            nerr++;
            $display("FAIL ignore_busy_no_second: active_cycles=%0d bcd=%h want 0 %h",
                     extra, bcd, exp_bcd(205));
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        kick(4321);                      // cycle 1
        for (int i = 0; i < 6; i++) tick();  // cycle 7
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nchk++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0 || overflow !== 1'b0
            || blank !== exp_blank_rst()) begin
            nerr++;
            $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b blank=%b want 0 0 0000 0 %b",
                     busy, done, bcd, overflow, blank, exp_blank_rst());
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) seen++;
        end
        nchk++;
        if (seen !== 0) begin
            nerr++;
            $display("FAIL reset_mid_no_done: active_cycles=%0d want 0", seen);
        end
        // rst wins over start on the same edge
        rst = 1'b1; start = 1'b1; bin = W'(5);
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        nchk++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_over_start: busy=%b want 0", busy);
        end
        test_convert("max_input", 16383);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit bok;
        kick(42);
        wait_done(1, cyc, bok);
        nchk++;
        if (cyc !== W + 1 || bcd !== exp_bcd(42)) begin
            nerr++;
            $display("FAIL b2b_first: cycle=%0d bcd=%h want %0d %h", cyc, bcd, W + 1, exp_bcd(42));
        end
        kick(8765);                      // issued in the done cycle
        wait_done(1, cyc, bok);
        nchk++;
        if (cyc !== W + 1 || !bok || bcd !== exp_bcd(8765) || overflow !== 1'b0
            || blank !== exp_blank(8765)) begin
            nerr++;
            $display("FAIL b2b_second: cycle=%0d busy_ok=%b bcd=%h ovf=%b blank=%b want %0d 1 %h 0 %b",
                     cyc, bok, bcd, overflow, blank, W + 1, exp_bcd(8765), exp_blank(8765));
        end
        tick();
    endtask

    task automatic test_random();
        int unsigned v;
        int cyc;
        bit bok;
        for (int n = 0; n < 40; n++) begin
            case (n % 4)
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, MAXV);
                2: v = $urandom_range(MAXV + 1, (1 << W) - 1);
                default: v = $urandom_range(0, (1 << W) - 1);
            endcase
            kick(v);
            wait_done(1, cyc, bok);
            nchk++;
            if (cyc !== W + 1 || bcd !== exp_bcd(v) || overflow !== (v > MAXV)
                || blank !== exp_blank(v)) begin
                nerr++;
                $display("FAIL random v=%0d: cycle=%0d bcd=%h ovf=%b blank=%b want %0d %h %b %b",
                         v, cyc, bcd, overflow, blank, W + 1, exp_bcd(v), (v > MAXV), exp_blank(v));
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_convert("bin1234", 1234);
        test_convert("bin0", 0);
        test_convert("bin9999", 9999);
        test_convert("bin12000_ovf", 12000);
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
